// File: rtl/pc16.sv
// pc16: 16-bit Hack program counter (clear > load > inc > hold).
// Optional registered wrap pulse when PC16_WRAP_FLAG_EN is defined.
module pc16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] in,
   input  logic        load,
   input  logic        inc,
   input  logic        clr,
   output logic [15:0] out
`ifdef PC16_WRAP_FLAG_EN
   ,
   output logic        wrap
`endif
);

   logic [15:0] q;
   logic [15:0] c;
   logic [15:0] q_inc;
   logic [15:0] m_inc;
   logic [15:0] m_load;
   logic [15:0] d;
   logic        keep;

   // Half-adder ripple with carry-in tied to 1
   assign c[0] = 1'b1;
   genvar i;
   generate
      for (i = 0; i < 16; i++) begin : g_inc
         assign q_inc[i] = q[i] ^ c[i];
         if (i < 15) begin : g_c
            assign c[i+1] = q[i] & c[i];
         end
      end
   endgenerate

   assign m_inc  = (q & ~{16{inc}}) | (q_inc & {16{inc}});
   assign m_load = (m_inc & ~{16{load}}) | (in & {16{load}});
   assign keep   = ~clr & rst_n;
   assign d      = m_load & {16{keep}};

   always_ff @(posedge clk) begin
      if (!rst_n) q <= 16'h0000;
      else        q <= d;
   end

   assign out = q;

`ifdef PC16_WRAP_FLAG_EN
   logic c16;
   logic sel_inc;
   logic wrap_d;

   // Carry out of bit 15 only matters when increment is the chosen path
   assign c16     = q[15] & c[15];
   assign sel_inc = inc & ~load & keep;
   assign wrap_d  = c16 & sel_inc;

   always_ff @(posedge clk) begin
      if (!rst_n) wrap <= 1'b0;
      else        wrap <= wrap_d;
   end
`endif

endmodule

// File: tb/tb_pc16.sv
// tb_pc16: scoreboard bench for pc16, directed cases then random.
// Expected values come from a priority model using plain arithmetic.
module tb_pc16;

   logic        clk;
   logic        rst_n;
   logic [15:0] in;
   logic        load;
   logic        inc;
   logic        clr;
   logic [15:0] out;
`ifdef PC16_WRAP_FLAG_EN
   logic        wrap;
`endif

   pc16 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in),
      .load  (load),
      .inc   (inc),
      .clr   (clr),
      .out   (out)
`ifdef PC16_WRAP_FLAG_EN
      ,
      .wrap  (wrap)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] pc;
      logic        wr;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   m_q = 0;
   bit   stim_done = 0;

   task automatic drive(input bit r, input bit c, input bit l,
                        input bit n, input logic [15:0] v,
                        input string tag);
      exp_t e;
      int   nxt;
      bit   w;
      @(negedge clk);
      rst_n = r; clr = c; load = l; inc = n; in = v;
      w = 0;
      if (!r || c)  nxt = 0;
      else if (l)   nxt = v;
      else if (n) begin
         nxt = (m_q + 1) % 65536;
         w = (m_q == 65535);
      end
      else          nxt = m_q;
      m_q = nxt;
      e.pc = nxt[15:0];
      e.wr = w;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   // Monitor: compare each posedge result against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (out !== e.pc) begin
               miscompares++;
               $display("FAIL %s: out=%h expected %h at %0t",
                        e.tag, out, e.pc, $time);
            end
`ifdef PC16_WRAP_FLAG_EN
            vectors++;
            if (wrap !== e.wr) begin
               miscompares++;
               $display("FAIL %s wrap: wrap=%b expected %b at %0t",
                        e.tag, wrap, e.wr, $time);
            end
`endif
         end
      end
   end

   initial begin
      rst_n = 0; clr = 0; load = 0; inc = 0; in = 16'h0;
      drive(0, 0, 1, 0, 16'h1234, "reset_hold");
      drive(0, 0, 1, 0, 16'h1234, "reset_hold");
      drive(1, 0, 0, 0, 16'h0000, "post_reset_idle");
      drive(1, 0, 0, 0, 16'h0000, "post_reset_idle");
      for (int k = 0; k < 5; k++) drive(1, 0, 0, 1, 16'h0, "count");
      drive(1, 0, 0, 0, 16'h0, "hold");
      drive(1, 0, 0, 0, 16'h0, "hold");
      drive(1, 0, 1, 1, 16'h7FFF, "load_over_inc");
      drive(1, 0, 0, 1, 16'h0, "inc_after_load");
      drive(1, 1, 1, 1, 16'hABCD, "clr_priority");
      drive(1, 0, 1, 0, 16'h5555, "reload");
      drive(0, 0, 1, 1, 16'hABCD, "rst_priority");
      drive(1, 0, 0, 1, 16'h0, "resume_count");
      drive(1, 0, 1, 0, 16'hFFFE, "load_fffe");
      drive(1, 0, 0, 1, 16'h0, "inc_to_ffff");
      drive(1, 0, 0, 1, 16'h0, "wrap_to_0");
      drive(1, 0, 0, 1, 16'h0, "after_wrap");
      drive(1, 0, 1, 0, 16'h0000, "load_zero");
      drive(1, 0, 1, 0, 16'hFFFF, "load_ffff");
      drive(1, 1, 0, 1, 16'h0, "clr_at_ffff");
      drive(1, 0, 1, 0, 16'hFFFF, "load_ffff");
      drive(0, 0, 0, 1, 16'h0, "rst_at_ffff");
      for (int k = 0; k < 10000; k++) begin
         bit r, c, l, n;
         logic [15:0] v;
         r = ($urandom_range(0, 63) != 0);
         c = ($urandom_range(0, 31) == 0);
         l = ($urandom_range(0, 7) == 0);
         n = ($urandom_range(0, 3) != 0);
         v = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
         drive(r, c, l, n, v, "random");
      end
      drive(1, 0, 0, 0, 16'h0, "final_hold");
      stim_done = 1;
   end

   initial begin
      int guard;
      wait (stim_done);
      guard = 0;
      while (exp_q.size() != 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #2;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: pending=%0d expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares + 1);
      $fatal(1, "timeout");
   end

endmodule
